// File: rtl/acorn_pkg.sv
// Shared ACORN-128 constants, tap indices, boolean helpers and FSM encodings.
// Used by the initialization engine and the one-step state update.
package acorn_pkg;

    localparam int STATE_W    = 293;
    localparam int KEY_W      = 128;
    localparam int IV_W       = 128;
    localparam int INIT_STEPS = 1792;
    localparam int CNT_W      = 11;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(INIT_STEPS - 1);

    // State bit positions touched by the update function
    localparam int TAP_0   = 0;
    localparam int TAP_12  = 12;
    localparam int TAP_23  = 23;
    localparam int TAP_61  = 61;
    localparam int TAP_66  = 66;
    localparam int TAP_107 = 107;
    localparam int TAP_111 = 111;
    localparam int TAP_154 = 154;
    localparam int TAP_160 = 160;
    localparam int TAP_193 = 193;
    localparam int TAP_196 = 196;
    localparam int TAP_230 = 230;
    localparam int TAP_235 = 235;
    localparam int TAP_244 = 244;
    localparam int TAP_289 = 289;

    // FSM encodings
    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic ch(input logic x, input logic y, input logic z);
        return (x & y) ^ (~x & z);
    endfunction

    // Message bit m_idx; beyond 256 the key repeats, with m_256 holding the padding one.
    function automatic logic message_bit(input logic [KEY_W-1:0] key,
                                         input logic [IV_W-1:0]  iv,
                                         input logic [CNT_W-1:0] idx);
        if (idx < 11'd128)
            return key[idx[6:0]];
        else if (idx < 11'd256)
            return iv[idx[6:0]];
        else
            return key[idx[6:0]] ^ (idx == 11'd256);
    endfunction

endpackage

// File: rtl/acorn128_initialization_if.sv
// Key/IV load and state/status bus of the ACORN-128 initialization engine.
interface acorn128_initialization_if;
    import acorn_pkg::*;

    logic [KEY_W-1:0]      key_in;
    logic [IV_W-1:0]       iv_in;
    logic [STATE_W-1:0]    state_out;
    logic [INIT_STEPS-1:0] mbit_out;
    logic                  ca_out;
    logic                  cb_out;
    logic                  done_out;

    modport master (
        output key_in, iv_in,
        input  state_out, mbit_out, ca_out, cb_out, done_out
    );

    modport slave (
        input  key_in, iv_in,
        output state_out, mbit_out, ca_out, cb_out, done_out
    );

endinterface

// File: rtl/acorn_state_update.sv
// One combinational ACORN state-update step; each LFSR fold sees the folds above it.
module acorn_state_update
    import acorn_pkg::*;
(
    input  logic [STATE_W-1:0] s,
    input  logic               m,
    input  logic               ca,
    input  logic               cb,
    output logic [STATE_W-1:0] s_next,
    output logic               ks
);

    logic [STATE_W-1:0] t;
    logic               f;

    always_comb begin
        t = s;
        t[TAP_289] = t[TAP_289] ^ t[TAP_235] ^ t[TAP_230];
        t[TAP_230] = t[TAP_230] ^ t[TAP_196] ^ t[TAP_193];
        t[TAP_193] = t[TAP_193] ^ t[TAP_160] ^ t[TAP_154];
        t[TAP_154] = t[TAP_154] ^ t[TAP_111] ^ t[TAP_107];
        t[TAP_107] = t[TAP_107] ^ t[TAP_66]  ^ t[TAP_61];
        t[TAP_61]  = t[TAP_61]  ^ t[TAP_23]  ^ t[TAP_0];

        ks = t[TAP_12] ^ t[TAP_154]
           ^ maj(t[TAP_235], t[TAP_61], t[TAP_193])
           ^ ch(t[TAP_230], t[TAP_111], t[TAP_66]);

        f = t[TAP_0] ^ ~t[TAP_107]
          ^ maj(t[TAP_244], t[TAP_23], t[TAP_160])
          ^ (ca & t[TAP_196]) ^ (cb & ks) ^ m;

        s_next = {f, t[STATE_W-1:1]};
    end

endmodule

// File: rtl/acorn128_initialization.sv
// ACORN-128 initialization: LOAD key/IV, RUN 1792 update steps, then hold in DONE.
// ACORN_MBIT_OUT_EN exposes the full registered message vector on mbit_out.
module acorn128_initialization
    import acorn_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    acorn128_initialization_if.slave    bus
);

    logic [1:0]         fsm;
    logic [CNT_W-1:0]   cnt;
    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_next;
    logic               m_cur;
    logic               run;
    logic               ks_unused;

    assign run = (fsm == ST_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm   <= ST_LOAD;
            cnt   <= '0;
            state <= '0;
        end else begin
            case (fsm)
                ST_LOAD: begin
                    cnt <= '0;
                    fsm <= ST_RUN;
                end
                ST_RUN: begin
                    state <= state_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_STEP)
                        fsm <= ST_DONE;
                end
                default: ;
            endcase
        end
    end

`ifdef ACORN_MBIT_OUT_EN
    logic [INIT_STEPS-1:0] mbit_q;
    logic [INIT_STEPS-1:0] mbit_build;

    always_comb begin
        mbit_build = '0;
        for (int i = 0; i < INIT_STEPS; i++)
            mbit_build[i] = message_bit(bus.key_in, bus.iv_in, CNT_W'(i));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mbit_q <= '0;
        else if (fsm == ST_LOAD)
            mbit_q <= mbit_build;
    end

    assign m_cur        = mbit_q[cnt];
    assign bus.mbit_out = mbit_q;
`else
    // Only key and IV are kept; each message bit is regenerated from the step count.
    logic [KEY_W-1:0] key_q;
    logic [IV_W-1:0]  iv_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q <= '0;
            iv_q  <= '0;
        end else if (fsm == ST_LOAD) begin
            key_q <= bus.key_in;
            iv_q  <= bus.iv_in;
        end
    end

    assign m_cur        = message_bit(key_q, iv_q, cnt);
    assign bus.mbit_out = '0;
`endif

    acorn_state_update u_update (
        .s      (state),
        .m      (m_cur),
        .ca     (run),
        .cb     (run),
        .s_next (state_next),
        .ks     (ks_unused)
    );

    assign bus.state_out = state;
    assign bus.ca_out    = run;
    assign bus.cb_out    = run;
    assign bus.done_out  = (fsm == ST_DONE);

endmodule

// File: tb/tb_acorn128_initialization.sv
// Directed self-checking bench for acorn128_initialization (either ACORN_MBIT_OUT_EN build).
module tb_acorn128_initialization;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    acorn128_initialization_if bus ();

    acorn128_initialization dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Literal transcription of the update equations, ca = cb = 1
    function automatic logic [292:0] ref_step(input logic [292:0] s, input logic m);
        logic [292:0] t;
        logic a289, a230, a193, a154, a107, a61, ks, f;
        t = s;
        a289 = t[289] ^ t[235] ^ t[230];  t[289] = a289;
        a230 = t[230] ^ t[196] ^ t[193];  t[230] = a230;
        a193 = t[193] ^ t[160] ^ t[154];  t[193] = a193;
        a154 = t[154] ^ t[111] ^ t[107];  t[154] = a154;
        a107 = t[107] ^ t[66]  ^ t[61];   t[107] = a107;
        a61  = t[61]  ^ t[23]  ^ t[0];    t[61]  = a61;
        ks = t[12] ^ a154 ^ ((t[235] & a61) ^ (t[235] & a193) ^ (a61 & a193))
           ^ ((a230 & t[111]) ^ (~a230 & t[66]));
        f = t[0] ^ ~a107 ^ ((t[244] & t[23]) ^ (t[244] & t[160]) ^ (t[23] & t[160]))
          ^ t[196] ^ ks ^ m;
        return {f, t[292:1]};
    endfunction

    function automatic logic ref_m(input logic [127:0] k, input logic [127:0] v, input int i);
        if (i < 128)       return k[i];
        else if (i < 256)  return v[i-128];
        else if (i == 256) return ~k[0];
        else               return k[i % 128];
    endfunction

    function automatic logic [292:0] ref_run(input logic [127:0] k, input logic [127:0] v, input int n);
        logic [292:0] s;
        s = '0;
        for (int i = 0; i < n; i++)
            s = ref_step(s, ref_m(k, v, i));
        return s;
    endfunction

    task automatic checkOutput(input string tag, input logic [292:0] observed, input logic [292:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Reset with the given key/IV, release on a falling edge; next rising edge is edge 1
    task automatic applyStimulus(input logic [127:0] k, input logic [127:0] v);
        @(negedge clk);
        rst = 1'b1;
        bus.key_in = k;
        bus.iv_in  = v;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic stepEdges(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic runToDone(input int start, output int edges);
        edges = start;
        while (bus.done_out !== 1'b1 && edges < 2100) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
    endtask

    logic [127:0] key_a;
    logic [127:0] iv_b;
    logic [127:0] pat01;
    logic [292:0] final_ref;
    logic [1791:0] exp_mbit;
    int           edges;
    int           exp_ones;

    initial begin
        key_a = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        iv_b  = 128'h123456789abcdef0fedcba9876543210;
        pat01 = {16{8'h01}};
        bus.key_in = '0;
        bus.iv_in  = '0;
        rst = 1'b1;

        repeat (3) @(negedge clk);
        checkOutput("reset_state", bus.state_out, '0);
        checkOutput("reset_mbit_ones", 293'($countones(bus.mbit_out)), '0);
        checkOutput("reset_ca", 293'(bus.ca_out), '0);
        checkOutput("reset_cb", 293'(bus.cb_out), '0);
        checkOutput("reset_done", 293'(bus.done_out), '0);

        // key = iv = 0
        applyStimulus('0, '0);
        stepEdges(1);
`ifdef ACORN_MBIT_OUT_EN
        exp_mbit = '0;
        exp_mbit[256] = 1'b1;
        exp_ones = 1;
`else
        exp_mbit = '0;
        exp_ones = 0;
`endif
        checkOutput("zero_mbit_low", bus.mbit_out[292:0], exp_mbit[292:0]);
        checkOutput("zero_mbit_ones", 293'($countones(bus.mbit_out)), 293'(exp_ones));
        checkOutput("run_ca", 293'(bus.ca_out), 293'(1));
        checkOutput("run_cb", 293'(bus.cb_out), 293'(1));
        checkOutput("run_done", 293'(bus.done_out), '0);
        checkOutput("zero_pre_step", bus.state_out, '0);
        stepEdges(1);
        checkOutput("zero_step0", bus.state_out, 293'(1) << 292);
        stepEdges(1);
        checkOutput("zero_step1", bus.state_out, 293'(3) << 291);
        runToDone(3, edges);
        checkOutput("zero_done_edges", 293'(edges), 293'(1793));
        final_ref = ref_run('0, '0, 1792);
        checkOutput("zero_final", bus.state_out, final_ref);
        stepEdges(12);
        checkOutput("zero_hold_state", bus.state_out, final_ref);
        checkOutput("done_ca", 293'(bus.ca_out), '0);
        checkOutput("done_cb", 293'(bus.cb_out), '0);
        checkOutput("done_flag", 293'(bus.done_out), 293'(1));

        // key = iv = {16{8'h01}}
        applyStimulus(pat01, pat01);
        stepEdges(1);
`ifdef ACORN_MBIT_OUT_EN
        checkOutput("p01_m0",   293'(bus.mbit_out[0]),   293'(1));
        checkOutput("p01_m8",   293'(bus.mbit_out[8]),   293'(1));
        checkOutput("p01_m256", 293'(bus.mbit_out[256]), '0);
        checkOutput("p01_m257", 293'(bus.mbit_out[257]), '0);
        checkOutput("p01_m264", 293'(bus.mbit_out[264]), 293'(1));
`else
        checkOutput("p01_mbit_ones", 293'($countones(bus.mbit_out)), '0);
`endif
        stepEdges(1);
        checkOutput("p01_step0", bus.state_out, '0);

        // Key/IV changed mid-RUN must not affect the result
        applyStimulus(key_a, iv_b);
        stepEdges(2);
        checkOutput("ab_step0", bus.state_out, ref_run(key_a, iv_b, 1));
        stepEdges(100);
        bus.key_in = ~key_a;
        bus.iv_in  = ~iv_b;
        runToDone(102, edges);
        checkOutput("ab_done_edges", 293'(edges), 293'(1793));
        final_ref = ref_run(key_a, iv_b, 1792);
        checkOutput("ab_final_keychg", bus.state_out, final_ref);

        // Reset asserted around step 500, then a clean rerun
        applyStimulus(key_a, iv_b);
        stepEdges(501);
        checkOutput("ab_step499", bus.state_out, ref_run(key_a, iv_b, 500));
        rst = 1'b1;
        #1;
        checkOutput("midrst_state", bus.state_out, '0);
        checkOutput("midrst_ca", 293'(bus.ca_out), '0);
        checkOutput("midrst_done", 293'(bus.done_out), '0);
        checkOutput("midrst_mbit_ones", 293'($countones(bus.mbit_out)), '0);
        @(negedge clk);
        rst = 1'b0;
        runToDone(0, edges);
        checkOutput("rerun_done_edges", 293'(edges), 293'(1793));
        checkOutput("rerun_final", bus.state_out, final_ref);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
